// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decode and event FIFO
module ps2_key_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 8191,
    parameter int FIFO_DEPTH     = 8,
    parameter int ERR_W          = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_dat,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [7:0]       key_code,
    output logic             key_extended,
    output logic             key_release,
    output logic [ERR_W-1:0] err_count,
    output logic             overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronisers idle high so reset never fabricates a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   sample_edge;

    assign clk_s       = clk_sync[SYNC_STAGES-1];
    assign dat_s       = dat_sync[SYNC_STAGES-1];
    assign sample_edge = clk_prev & ~clk_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev <= clk_s;
        end
    end

    state_t          state;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic            parity_ok;
    logic            ext_flag;
    logic            rel_flag;
    logic [TO_W-1:0] to_cnt;
    logic            push_valid;
    logic [9:0]      push_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_ok  <= 1'b0;
            ext_flag   <= 1'b0;
            rel_flag   <= 1'b0;
            to_cnt     <= TO_RELOAD;
            push_valid <= 1'b0;
            push_data  <= '0;
            err_count  <= '0;
        end else begin
            push_valid <= 1'b0;

            if (state == S_IDLE || sample_edge) begin
                to_cnt <= TO_RELOAD;
            end else if (to_cnt != '0) begin
                to_cnt <= to_cnt - TO_W'(1);
            end

            if (sample_edge) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_ok <= ^{shift, dat_s};
                        state     <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (parity_ok && dat_s) begin
                            if (shift == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else if (shift == 8'hF0) begin
                                rel_flag <= 1'b1;
                            end else begin
                                push_valid <= 1'b1;
                                push_data  <= {ext_flag, rel_flag, shift};
                                ext_flag   <= 1'b0;
                                rel_flag   <= 1'b0;
                            end
                        end else begin
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE && to_cnt == '0) begin
                // Stalled frame: drop it silently, prefixes survive.
                state   <= S_IDLE;
                bit_cnt <= '0;
            end
        end
    end

    logic [9:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic [9:0]  head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = key_valid & key_ready;
    assign push_ok = push_valid & (~full | pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head fields are masked while empty so stale memory never shows.
    assign key_valid    = ~empty;
    assign key_code     = key_valid ? head[7:0] : 8'h00;
    assign key_release  = key_valid & head[8];
    assign key_extended = key_valid & head[9];

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - scoreboard bench for ps2_key_rx
module tb_ps2_key_rx;

    localparam int TB_TIMEOUT = 300;
    localparam int TB_DEPTH   = 4;
    localparam int TB_ERR_W   = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                ps2_clk = 1'b1;
    logic                ps2_dat = 1'b1;
    logic                key_ready = 1'b1;
    logic                key_valid;
    logic [7:0]          key_code;
    logic                key_extended;
    logic                key_release;
    logic [TB_ERR_W-1:0] err_count;
    logic                overflow;

    int vectors = 0;
    int miscompares = 0;
    int valid_cycles = 0;
    logic [9:0] exp_q[$];

    ps2_key_rx #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .FIFO_DEPTH(TB_DEPTH),
        .ERR_W(TB_ERR_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_code(key_code),
        .key_extended(key_extended),
        .key_release(key_release),
        .err_count(err_count),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && key_valid === 1'b1) begin
            valid_cycles++;
            if (key_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected got %h want none", {key_extended, key_release, key_code});
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({key_extended, key_release, key_code} !== e) begin
                        miscompares++;
                        $display("FAIL sb_event got %h want %h", {key_extended, key_release, key_code}, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, output int lat);
        ps2_dat = b;
        tick(5);
        ps2_clk = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (lat == 0 && key_valid === 1'b1) lat = i;
        end
        @(posedge clock);
        #1;
        ps2_clk = 1'b1;
        tick(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_b, output int lat);
        int l;
        send_bit(1'b0, l);
        for (int i = 0; i < 8; i++) send_bit(b[i], l);
        send_bit((~^b) ^ par_bad, l);
        send_bit(stop_b, lat);
        ps2_dat = 1'b1;
        tick(10);
    endtask

    task automatic send_good(input logic [7:0] b);
        int l;
        send_frame(b, 1'b0, 1'b1, l);
    endtask

    task automatic send_partial(input int nbits);
        int l;
        for (int i = 0; i < nbits; i++) send_bit(i == 0 ? 1'b0 : 1'b1, l);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain got %0d pending want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({key_valid, key_code, key_extended, key_release} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_head got %h want 0", {key_valid, key_code, key_extended, key_release});
        end
        vectors++;
        if (err_count !== '0) begin
            miscompares++;
            $display("FAIL reset_err got %0d want 0", err_count);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf got %b want 0", overflow);
        end
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        key_ready = 1'b1;
        valid_cycles = 0;
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1, lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL single_latency got %0d want 5", lat);
        end
        vectors++;
        if (valid_cycles !== 1) begin
            miscompares++;
            $display("FAIL single_valid_cycles got %0d want 1", valid_cycles);
        end
        check_drained("single");
    endtask

    task automatic test_prefix();
        do_reset();
        key_ready = 1'b1;
        exp_q.push_back({2'b11, 8'h74});
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h74);
        exp_q.push_back({2'b00, 8'h1C});
        send_good(8'h1C);
        exp_q.push_back({2'b10, 8'h75});
        send_good(8'hE0);
        send_good(8'h75);
        exp_q.push_back({2'b01, 8'h76});
        send_good(8'hF0);
        send_good(8'h76);
        check_drained("prefix");
    endtask

    task automatic test_parity();
        int l;
        do_reset();
        key_ready = 1'b1;
        send_frame(8'h1C, 1'b1, 1'b1, l);
        exp_q.push_back({2'b00, 8'h1B});
        send_good(8'h1B);
        vectors++;
        if (err_count !== 3'd1) begin
            miscompares++;
            $display("FAIL parity_err got %0d want 1", err_count);
        end
        send_frame(8'h33, 1'b0, 1'b0, l);
        send_good(8'hE0);
        send_frame(8'h44, 1'b1, 1'b1, l);
        exp_q.push_back({2'b00, 8'h22});
        send_good(8'h22);
        vectors++;
        if (err_count !== 3'd3) begin
            miscompares++;
            $display("FAIL stop_err got %0d want 3", err_count);
        end
        check_drained("parity");
    endtask

    task automatic test_timeout();
        do_reset();
        key_ready = 1'b1;
        send_partial(5);
        tick(TB_TIMEOUT + 10);
        exp_q.push_back({2'b00, 8'h2A});
        send_good(8'h2A);
        vectors++;
        if (err_count !== 3'd0) begin
            miscompares++;
            $display("FAIL timeout_err got %0d want 0", err_count);
        end
        send_good(8'hF0);
        send_partial(3);
        tick(TB_TIMEOUT + 10);
        exp_q.push_back({2'b01, 8'h2B});
        send_good(8'h2B);
        check_drained("timeout");
    endtask

    task automatic test_overflow();
        do_reset();
        key_ready = 1'b0;
        send_good(8'h11);
        vectors++;
        if ({key_valid, key_code} !== {1'b1, 8'h11}) begin
            miscompares++;
            $display("FAIL ovf_first got %h want 111", {key_valid, key_code});
        end
        send_good(8'h12);
        send_good(8'h13);
        send_good(8'h14);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_at_full got %b want 0", overflow);
        end
        send_good(8'h15);
        vectors++;
        if ({key_valid, overflow, key_code} !== {2'b11, 8'h11}) begin
            miscompares++;
            $display("FAIL ovf_flag got %h want 311", {key_valid, overflow, key_code});
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, 8'h11 + 8'(i)});
        key_ready = 1'b1;
        tick(10);
        check_drained("overflow");
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_empty got %b want 0", key_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        key_ready = 1'b1;
        send_partial(5);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        exp_q.push_back({2'b00, 8'h15});
        send_good(8'h15);
        vectors++;
        if ({overflow, err_count} !== 4'd0) begin
            miscompares++;
            $display("FAIL midreset_status got %h want 0", {overflow, err_count});
        end
        check_drained("midreset");
    endtask

    task automatic test_saturate();
        int l;
        do_reset();
        key_ready = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 6; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b1, l);
        vectors++;
        if (err_count !== 3'd6) begin
            miscompares++;
            $display("FAIL sat_count got %0d want 6", err_count);
        end
        for (int i = 0; i < 3; i++) send_frame(8'h50 + 8'(i), 1'b1, 1'b1, l);
        vectors++;
        if (err_count !== 3'd7) begin
            miscompares++;
            $display("FAIL sat_hold got %0d want 7", err_count);
        end
        vectors++;
        if (valid_cycles !== 0) begin
            miscompares++;
            $display("FAIL sat_no_event got %0d want 0", valid_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per PS/2 input, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8191: idle clocks mid-frame before the frame is abandoned.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries, power of two, minimum 2.
REQ-004 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-005 SHALL have port clock, input, 1: system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ps2_clk, input, 1: raw, asynchronous PS/2 clock line.
REQ-008 SHALL have port ps2_dat, input, 1: raw, asynchronous PS/2 data line.
REQ-009 SHALL have port key_valid, output, 1: FIFO head holds an event.
REQ-010 SHALL have port key_ready, input, 1: consumer accepts the head event.
REQ-011 SHALL have port key_code, output, 8: scan code of the head event.
REQ-012 SHALL have port key_extended, output, 1: head event was preceded by 0xE0.
REQ-013 SHALL have port key_release, output, 1: head event was preceded by 0xF0.
REQ-014 SHALL have port err_count, output, ERR_W: saturating count of rejected frames.
REQ-015 SHALL have port overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.

Function
REQ-016 SHALL pass ps2_clk and ps2_dat through SYNC_STAGES flops before use; a sample edge is synchronised clk 1 on the previous cycle and 0 on the current cycle.
REQ-017 SHALL run the frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on a sample edge.
REQ-018 In IDLE, a sampled 0 SHALL enter DATA with bit count 0; a sampled 1 SHALL be ignored and leave the FSM in IDLE.
REQ-019 In DATA, each edge SHALL shift the data bit in LSB-first; the 8th bit SHALL move the FSM to PARITY.
REQ-020 In PARITY, the FSM SHALL record odd-parity correctness (data plus parity bit has an odd number of ones) and move to STOP.
REQ-021 In STOP, the FSM SHALL return to IDLE; the frame is good only if parity was correct and the stop bit is 1.
REQ-022 A bad frame SHALL produce no event, SHALL clear both prefix flags, and SHALL increment err_count, which saturates at all-ones.
REQ-023 A good frame with byte 0xE0 SHALL set the extended flag and push nothing.
REQ-024 A good frame with byte 0xF0 SHALL set the release flag and push nothing.
REQ-025 Any other good byte SHALL push {extended, release, byte} into the FIFO and clear both prefix flags in the same cycle.
REQ-026 The timeout counter SHALL reload to TIMEOUT_CYCLES on every sample edge and whenever the FSM is in IDLE.
REQ-027 Outside IDLE, the timeout counter SHALL decrement by 1 per clock; on reaching 0 the FSM SHALL return to IDLE, discard the partial frame, and leave the prefix flags and err_count unchanged.
REQ-028 key_valid, key_code, key_extended and key_release SHALL be driven from the FIFO head; key_valid is high exactly when the FIFO is non-empty.
REQ-029 The FIFO SHALL pop on a cycle with key_valid and key_ready both high; key_code and the flags SHALL hold steady while key_valid is high and key_ready is low.
REQ-030 Latency: key_valid SHALL rise exactly 2 clocks after the cycle in which the stop-bit sample edge is detected, when the FIFO was empty.
REQ-031 A push to a full FIFO SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case both the push and the pop SHALL complete.
REQ-032 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the occupancy unchanged.
REQ-033 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.

Reset
REQ-034 While reset is high, the FSM SHALL be forced to IDLE, the shift register, bit count and prefix flags SHALL clear, the FIFO SHALL be emptied, the timeout SHALL reload, and all synchroniser flops SHALL be set to 1.
REQ-035 After reset, all outputs SHALL be 0: key_valid, key_code, key_extended, key_release, err_count and overflow.
REQ-036 Reset asserted mid-frame SHALL abandon the frame with no event, no error count and no overflow.

Verification
REQ-037 Frame for byte 0x1C with correct parity, key_ready held high -> one event: code 0x1C, ext 0, rel 0; key_valid high for 1 clock.
REQ-038 Frames E0, F0, 74 -> exactly one event: code 0x74, ext 1, rel 1; the next frame 0x1C -> event with ext 0, rel 0.
REQ-039 Frame for byte 0x1C with a wrong parity bit, then frame 0x1B -> err_count = 1; only the 0x1B event is produced.
REQ-040 Five bits of a frame, then ps2_clk held high for TIMEOUT_CYCLES+10 clocks, then a full frame 0x2A -> single event 0x2A, err_count = 0.
REQ-041 FIFO_DEPTH = 4, key_ready low, five make codes sent -> key_valid high and overflow = 1; the first four codes pop in order and the fifth is absent.
REQ-042 Reset pulsed after the 4th data bit of a frame, then frame 0x15 sent -> one event 0x15; overflow = 0, err_count = 0.
